ladybird_fetch_queue: RTL

//  Fetch control and instruction buffer around ladybird_ifu. Generates sequential fetch PCs,

---
 rtl/ladybird_fetch_queue_if.sv | 36 +++
 rtl/ladybird_fetch_queue.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ladybird_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// ladybird_fetch_queue_if
//  Bundles every non-clock/reset signal of the fetch queue:
//   redirect_valid/redirect_pc : pipeline flush and restart target
//   pc/pc_valid/pc_ready       : fetch request channel towards the IFU
//   inst/inst_valid/inst_pc    : IFU response channel (no backpressure)
//   out_inst/out_pc/out_valid/out_ready : instruction stream towards decode
//  master : the fetch queue itself
//  slave  : the environment (IFU, decode, redirect source)
// ---------------------------------------------------------------------------
interface ladybird_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] inst;
  logic            inst_valid;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_valid;
  logic            out_ready;

  modport master (
    input  redirect_valid, redirect_pc, pc_ready, inst, inst_valid, inst_pc, out_ready,
    output pc, pc_valid, out_inst, out_pc, out_valid
  );

  modport slave (
    output redirect_valid, redirect_pc, pc_ready, inst, inst_valid, inst_pc, out_ready,
    input  pc, pc_valid, out_inst, out_pc, out_valid
  );
endinterface

// File: rtl/ladybird_fetch_queue.sv
// ---------------------------------------------------------------------------
// ladybird_fetch_queue
//  Fetch control and instruction buffer in front of the IFU. Generates
//  sequential fetch PCs, issues them under a credit limit (in-flight plus
//  buffered never exceeds DEPTH), buffers IFU responses in a FIFO towards
//  decode, and discards responses made stale by a redirect.
// Ports
//  clk      : clock, all state updates on posedge
//  rst      : synchronous active-high reset
//  fetch_if : ladybird_fetch_queue_if.master (redirect, IFU request/response,
//             decode output)
// ---------------------------------------------------------------------------
module ladybird_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input logic                       clk,
  input logic                       rst,
  ladybird_fetch_queue_if.master    fetch_if
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [AW-1:0]   PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            redir_pend_q, redir_pend_d;
  logic            held_q, held_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] mem_inst_q [DEPTH];
  logic [XLEN-1:0] mem_pc_q   [DEPTH];

  logic            credit_ok_s;
  logic            pc_valid_s;
  logic            fire_s;
  logic            resp_s;
  logic            drop_dec_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   redir_drop_s;

  // Credit counts requests already in flight as well as buffered entries, so
  // every response always has a FIFO slot waiting for it.
  assign credit_ok_s = (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W);
  // A held request stays valid regardless of credit or redirect.
  assign pc_valid_s  = ~rst & (held_q | (credit_ok_s & ~fetch_if.redirect_valid));
  assign fire_s      = pc_valid_s & fetch_if.pc_ready;
  assign resp_s      = fetch_if.inst_valid;
  assign drop_dec_s  = resp_s & (drop_cnt_q != CNT_ZERO);
  assign push_s      = resp_s & (drop_cnt_q == CNT_ZERO) & ~fetch_if.redirect_valid;
  assign pop_s       = (count_q != CNT_ZERO) & fetch_if.out_ready;
  // Everything outstanding becomes stale, except a response retiring this cycle.
  assign redir_drop_s = inflight_q - CW'(resp_s);

  assign fetch_if.pc        = pc_q;
  assign fetch_if.pc_valid  = pc_valid_s;
  assign fetch_if.out_valid = (count_q != CNT_ZERO);
  assign fetch_if.out_inst  = mem_inst_q[rd_ptr_q];
  assign fetch_if.out_pc    = mem_pc_q[rd_ptr_q];

  // Next-state logic for fetch PC, redirect bookkeeping, counters and pointers.
  always_comb begin
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    drop_cnt_d   = drop_cnt_q;
    held_d       = pc_valid_s & ~fetch_if.pc_ready;
    inflight_d   = inflight_q + CW'(fire_s) - CW'(resp_s);

    if (fetch_if.redirect_valid) begin
      if (fire_s) begin
        // Held request leaves now, but it was fetched down the old path.
        drop_cnt_d   = redir_drop_s + CNT_ONE;
        pc_d         = fetch_if.redirect_pc;
        redir_pend_d = 1'b0;
      end else if (held_q) begin
        // pc must stay stable until the handshake; park the target.
        drop_cnt_d   = redir_drop_s;
        redir_pc_d   = fetch_if.redirect_pc;
        redir_pend_d = 1'b1;
      end else begin
        drop_cnt_d   = redir_drop_s;
        pc_d         = fetch_if.redirect_pc;
        redir_pend_d = 1'b0;
      end
    end else begin
      if (fire_s) begin
        if (redir_pend_q) begin
          drop_cnt_d   = drop_cnt_q - CW'(drop_dec_s) + CNT_ONE;
          pc_d         = redir_pc_q;
          redir_pend_d = 1'b0;
        end else begin
          drop_cnt_d   = drop_cnt_q - CW'(drop_dec_s);
          pc_d         = pc_q + PC_STEP;
        end
      end else begin
        drop_cnt_d = drop_cnt_q - CW'(drop_dec_s);
      end
    end

    if (fetch_if.redirect_valid) begin
      count_d  = CNT_ZERO;
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
    end else begin
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      held_q       <= 1'b0;
      inflight_q   <= CNT_ZERO;
      count_q      <= CNT_ZERO;
      drop_cnt_q   <= CNT_ZERO;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
    end else begin
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      held_q       <= held_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observed while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_inst_q[wr_ptr_q] <= fetch_if.inst;
      mem_pc_q[wr_ptr_q]   <= fetch_if.inst_pc;
    end
  end

endmodule
